// File: rtl/cmd_phys_arbiter_pkg.sv
// cmd_phys_arbiter_pkg: shared SD-host CMD definitions (frame layout, widths, arbiter states)
package cmd_phys_arbiter_pkg;
    localparam int CMD_W_DEF     = 40;
    localparam int RESP_W_DEF    = 136;
    localparam int CMD_START_BIT = 39;
    localparam int CMD_DIR_BIT   = 38;
    localparam int CMD_IDX_HI    = 37;
    localparam int CMD_IDX_LO    = 32;
    localparam int CMD_ARG_HI    = 31;
    localparam int CMD_ARG_LO    = 0;
    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_ISSUE   = 3'b010,
        ST_DELIVER = 3'b100
    } state_t;
endpackage

// File: rtl/cmd_rr_pick.sv
// cmd_rr_pick: two-way round-robin chooser, favouring the requester not served last
module cmd_rr_pick (
    input  logic req_0,
    input  logic req_1,
    input  logic last,
    output logic valid,
    output logic idx
);
    assign valid = req_0 || req_1;
    assign idx   = (req_0 && req_1) ? !last : req_1;
endmodule

// File: rtl/cmd_phys_arbiter.sv
// cmd_phys_arbiter: shares the SD CMD physical layer between the host command
// controller (0) and the auto-command engine (1), with a completion watchdog.
module cmd_phys_arbiter
    import cmd_phys_arbiter_pkg::*;
#(
    parameter int CMD_W    = CMD_W_DEF,
    parameter int RESP_W   = RESP_W_DEF,
    parameter int WDOG_W   = 16,
    parameter int WDOG_CYC = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_strobe_0,
    input  logic [CMD_W-1:0]  req_cmd_0,
    input  logic              req_ack_0,
    input  logic              req_strobe_1,
    input  logic [CMD_W-1:0]  req_cmd_1,
    input  logic              req_ack_1,
    output logic              done_0,
    output logic              done_1,
    output logic [RESP_W-1:0] resp_0,
    output logic [RESP_W-1:0] resp_1,
    output logic              tout_0,
    output logic              tout_1,
    input  logic              timeout_enable,
    input  logic              serial_ready,
    input  logic              phy_strobe_in,
    input  logic [RESP_W-1:0] phy_cmd_in,
    input  logic              phy_time_out,
    output logic              phy_strobe,
    output logic [CMD_W-1:0]  phy_cmd,
    output logic              phy_ack,
    output logic              phy_idle
);
    state_t state, state_nx;
    logic sel, last, gnt_valid, gnt_idx, expire, event_hit, ack_sel, grant, tout_q;
    logic [WDOG_W-1:0] wdog;
    logic [CMD_W-1:0] cmd_q;
    logic [RESP_W-1:0] cap;

    cmd_rr_pick u_pick (
        .req_0 (req_strobe_0),
        .req_1 (req_strobe_1),
        .last  (last),
        .valid (gnt_valid),
        .idx   (gnt_idx)
    );

    assign grant     = state == ST_IDLE && serial_ready && gnt_valid;
    assign expire    = timeout_enable && wdog == WDOG_W'(WDOG_CYC - 1);
    assign event_hit = phy_strobe_in || phy_time_out || expire;
    assign ack_sel   = sel ? req_ack_1 : req_ack_0;
    // a real completion beats a simultaneous watchdog expiry
    assign cap       = (phy_strobe_in || !expire) ? phy_cmd_in : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = grant ? ST_ISSUE :
                   (state == ST_ISSUE && event_hit) ? ST_DELIVER :
                   (state == ST_DELIVER && ack_sel) ? ST_IDLE : state;
        phy_idle   = state == ST_IDLE;
        phy_strobe = state == ST_ISSUE;
        phy_cmd    = phy_strobe ? cmd_q : '0;
        phy_ack    = state == ST_DELIVER;
        done_0     = phy_ack && !sel;
        done_1     = phy_ack && sel;
        tout_0     = done_0 && tout_q;
        tout_1     = done_1 && tout_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sel    <= 1'b0;
            last   <= 1'b1;
            wdog   <= '0;
            cmd_q  <= '0;
            tout_q <= 1'b0;
            resp_0 <= '0;
            resp_1 <= '0;
        end else begin
            if (grant) begin
                sel   <= gnt_idx;
                cmd_q <= gnt_idx ? req_cmd_1 : req_cmd_0;
                wdog  <= '0;
            end else if (state == ST_ISSUE && timeout_enable) begin
                wdog <= wdog + 1'b1;
            end
            if (state == ST_ISSUE && event_hit) begin
                tout_q <= phy_time_out || (expire && !phy_strobe_in);
                if (sel) resp_1 <= cap;
                else resp_0 <= cap;
            end
            if (state == ST_DELIVER && ack_sel) last <= sel;
        end
    end
endmodule

// File: tb/tb_cmd_phys_arbiter.sv
// tb_cmd_phys_arbiter: directed scenarios plus randomized traffic checked every
// cycle against a transaction-level model of the arbiter.
module tb_cmd_phys_arbiter;
    localparam int WDOG_CYC = 8;
    logic clock = 0, reset = 0;
    logic req_strobe_0 = 0, req_ack_0 = 0, req_strobe_1 = 0, req_ack_1 = 0;
    logic [39:0] req_cmd_0 = '0, req_cmd_1 = '0;
    logic timeout_enable = 0, serial_ready = 0, phy_strobe_in = 0, phy_time_out = 0;
    logic [135:0] phy_cmd_in = '0;
    logic done_0, done_1, tout_0, tout_1, phy_strobe, phy_ack, phy_idle;
    logic [135:0] resp_0, resp_1;
    logic [39:0] phy_cmd;
    int errors = 0, checks = 0;

    cmd_phys_arbiter #(.WDOG_CYC(WDOG_CYC)) dut (
        .clock(clock), .reset(reset),
        .req_strobe_0(req_strobe_0), .req_cmd_0(req_cmd_0), .req_ack_0(req_ack_0),
        .req_strobe_1(req_strobe_1), .req_cmd_1(req_cmd_1), .req_ack_1(req_ack_1),
        .done_0(done_0), .done_1(done_1), .resp_0(resp_0), .resp_1(resp_1),
        .tout_0(tout_0), .tout_1(tout_1), .timeout_enable(timeout_enable),
        .serial_ready(serial_ready), .phy_strobe_in(phy_strobe_in), .phy_cmd_in(phy_cmd_in),
        .phy_time_out(phy_time_out), .phy_strobe(phy_strobe), .phy_cmd(phy_cmd),
        .phy_ack(phy_ack), .phy_idle(phy_idle)
    );

    always #5 clock = ~clock;

    // model: phase 0 waiting, 1 frame out on the phy, 2 result offered to the winner
    logic [1:0] m_ph;
    logic m_who, m_last, m_tout;
    logic [15:0] m_en;
    logic [39:0] m_frame;
    logic [135:0] m_resp [2];
    wire pick = (req_strobe_0 && req_strobe_1) ? !m_last : req_strobe_1;
    wire [15:0] en_nx = m_en + 16'(timeout_enable);
    wire wd = timeout_enable && en_nx == 16'(WDOG_CYC);

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_ph <= 0; m_who <= 0; m_last <= 1; m_tout <= 0; m_en <= 0; m_frame <= '0;
            m_resp[0] <= '0; m_resp[1] <= '0;
        end else if (m_ph == 0) begin
            if (serial_ready && (req_strobe_0 || req_strobe_1)) begin
                m_who <= pick; m_frame <= pick ? req_cmd_1 : req_cmd_0; m_en <= 0; m_ph <= 1;
            end
        end else if (m_ph == 1) begin
            m_en <= en_nx;
            if (phy_strobe_in || phy_time_out || wd) begin
                m_resp[m_who] <= (phy_strobe_in || !wd) ? phy_cmd_in : '0;
                m_tout <= phy_time_out || (wd && !phy_strobe_in);
                m_ph <= 2;
            end
        end else if (m_who ? req_ack_1 : req_ack_0) begin
            m_last <= m_who; m_ph <= 0;
        end
    end

    task automatic chk(input string n, input logic [135:0] a, input logic [135:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("phy_idle", phy_idle, m_ph == 0);
        chk("phy_strobe", phy_strobe, m_ph == 1);
        chk("phy_cmd", phy_cmd, m_ph == 1 ? m_frame : 40'h0);
        chk("phy_ack", phy_ack, m_ph == 2);
        chk("done_0", done_0, m_ph == 2 && !m_who);
        chk("done_1", done_1, m_ph == 2 && m_who);
        chk("tout_0", tout_0, m_ph == 2 && !m_who && m_tout);
        chk("tout_1", tout_1, m_ph == 2 && m_who && m_tout);
        chk("resp_0", resp_0, m_resp[0]);
        chk("resp_1", resp_1, m_resp[1]);
    end

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic txn(input logic who, input logic [39:0] cmd);
        tick;
        chk("grant_cmd", phy_cmd, cmd);
        phy_strobe_in = 1; phy_cmd_in = 136'(cmd) + 136'h1;
        tick;
        phy_strobe_in = 0;
        chk("grant_done", who ? done_1 : done_0, 1);
        chk("grant_resp", who ? resp_1 : resp_0, 136'(cmd) + 136'h1);
        req_ack_0 = 1; req_ack_1 = 1;
        tick;
        req_ack_0 = 0; req_ack_1 = 0;
        chk("grant_idle", phy_idle, 1);
    endtask

    initial begin
        tick; tick;
        reset = 1;
        chk("rst_idle", phy_idle, 1);
        chk("rst_strobe", phy_strobe, 0);
        chk("rst_resp0", resp_0, 0);
        // single request
        req_strobe_0 = 1; req_cmd_0 = 40'h4C_0000_0000; serial_ready = 1;
        tick;
        chk("single_strobe", phy_strobe, 1);
        chk("single_cmd", phy_cmd, 40'h4C_0000_0000);
        req_strobe_0 = 0; req_cmd_0 = 40'h11_2233_4455;
        tick;
        chk("single_hold_cmd", phy_cmd, 40'h4C_0000_0000);
        phy_strobe_in = 1; phy_cmd_in = 136'hA5;
        tick;
        phy_strobe_in = 0;
        chk("single_done", done_0, 1);
        chk("single_resp", resp_0, 136'hA5);
        chk("single_tout", tout_0, 0);
        chk("single_done1", done_1, 0);
        req_ack_0 = 1;
        tick;
        req_ack_0 = 0;
        chk("single_idle", phy_idle, 1);
        // tie from reset: 0, 1, 0
        reset = 0; tick; reset = 1;
        req_strobe_0 = 1; req_strobe_1 = 1;
        req_cmd_0 = 40'h40_1234_5678; req_cmd_1 = 40'h4C_8765_4321;
        txn(0, 40'h40_1234_5678);
        txn(1, 40'h4C_8765_4321);
        txn(0, 40'h40_1234_5678);
        // watchdog expiry after WDOG_CYC issue cycles
        req_strobe_1 = 0; timeout_enable = 1; phy_cmd_in = 136'hFFFF;
        tick;
        repeat (WDOG_CYC - 1) tick;
        chk("wdog_still_issue", phy_strobe, 1);
        tick;
        chk("wdog_done", done_0, 1);
        chk("wdog_tout", tout_0, 1);
        chk("wdog_resp", resp_0, 0);
        req_ack_0 = 1; tick; req_ack_0 = 0;
        // watchdog disabled, then physical layer timeout
        timeout_enable = 0;
        tick;
        repeat (40) tick;
        chk("nowdog_issue", phy_strobe, 1);
        chk("nowdog_done", done_0, 0);
        phy_time_out = 1; phy_cmd_in = 136'h77;
        tick;
        phy_time_out = 0;
        chk("pto_done", done_0, 1);
        chk("pto_tout", tout_0, 1);
        req_strobe_0 = 0; req_ack_0 = 1; tick; req_ack_0 = 0;
        // serial_ready gating
        serial_ready = 0; req_strobe_1 = 1; req_cmd_1 = 40'h4C_0000_0001;
        repeat (3) tick;
        chk("nosr_strobe", phy_strobe, 0);
        serial_ready = 1;
        tick;
        chk("sr_strobe", phy_strobe, 1);
        chk("sr_cmd", phy_cmd, 40'h4C_0000_0001);
        // asynchronous reset mid-issue
        #2 reset = 0;
        #1;
        chk("arst_strobe", phy_strobe, 0);
        chk("arst_idle", phy_idle, 1);
        tick;
        reset = 1; req_strobe_1 = 0; phy_strobe_in = 1;
        repeat (4) begin
            tick;
            chk("arst_nodone", {done_0, done_1}, 0);
        end
        phy_strobe_in = 0;
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset = !reset ? 1'b1 : ($urandom_range(0, 299) != 0);
            req_strobe_0 = $urandom_range(0, 2) == 0;
            req_strobe_1 = $urandom_range(0, 2) == 0;
            req_cmd_0 = {8'($urandom), $urandom};
            req_cmd_1 = {8'($urandom), $urandom};
            req_ack_0 = $urandom_range(0, 2) == 0;
            req_ack_1 = $urandom_range(0, 2) == 0;
            serial_ready = $urandom_range(0, 3) != 0;
            phy_strobe_in = $urandom_range(0, 11) == 0;
            phy_time_out = $urandom_range(0, 19) == 0;
            phy_cmd_in = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
            if ($urandom_range(0, 49) == 0) timeout_enable = !timeout_enable;
            tick;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
